// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer
//   Transmit-side frame sequencer for DAA/HDR transfers. On start it latches a
//   frame count N and asks the serializer for frames 0..N-1, one at a time,
//   over a level request / pulse done handshake. The final frame is flagged so
//   the serializer can close the transfer. Completion, abort and watchdog
//   timeout are reported.
// Parameters
//   CNT_W    width of frame count and frame index
//   TMO_CYC  REQ cycles allowed without i_fcnt_frm_done before timeout (0 = off)
// Ports
//   i_fcnt_clk         clock, rising edge
//   i_fcnt_rst_n       asynchronous active-low reset
//   i_fcnt_start       start pulse, honoured only in IDLE
//   i_fcnt_no_frms     frame count, latched on an accepted start
//   i_fcnt_frm_done    serializer pulse: current frame sent
//   i_fcnt_abort       synchronous abort, highest priority
//   o_fcnt_frm_req     level: send frame o_fcnt_frm_idx
//   o_fcnt_frm_idx     0-based index of the requested frame
//   o_fcnt_last_frame  requested frame is the last one
//   o_fcnt_busy        high in REQ and DONE
//   o_fcnt_done        1-cycle pulse: all frames sent
//   o_fcnt_err         1-cycle pulse: zero-length start or timeout
module tx_frame_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic             i_fcnt_clk,
    input  logic             i_fcnt_rst_n,
    input  logic             i_fcnt_start,
    input  logic [CNT_W-1:0] i_fcnt_no_frms,
    input  logic             i_fcnt_frm_done,
    input  logic             i_fcnt_abort,
    output logic             o_fcnt_frm_req,
    output logic [CNT_W-1:0] o_fcnt_frm_idx,
    output logic             o_fcnt_last_frame,
    output logic             o_fcnt_busy,
    output logic             o_fcnt_done,
    output logic             o_fcnt_err
);

    localparam int WD_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_total;
    logic [WD_W-1:0]  r_wdog;
    logic             r_err;

    logic w_last;
    logic w_wd_exp;

    // Compare at CNT_W bits so total = 2^CNT_W-1 needs no extra width.
    assign w_last = (r_idx == (r_total - CNT_W'(1)));

    // The counter holds the number of idle REQ cycles already seen; this
    // cycle being idle too makes TMO_CYC of them.
    assign w_wd_exp = (TMO_CYC != 0) && (r_wdog == WD_W'(TMO_CYC - 1));

    always_ff @(posedge i_fcnt_clk or negedge i_fcnt_rst_n) begin
        if (!i_fcnt_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_total <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (i_fcnt_abort) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_wdog  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_fcnt_start) begin
                            if (i_fcnt_no_frms == '0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_total <= i_fcnt_no_frms;
                                r_idx   <= '0;
                                r_wdog  <= '0;
                                r_state <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (i_fcnt_frm_done) begin
                            r_wdog <= '0;
                            if (w_last) r_state <= S_DONE;
                            else        r_idx   <= r_idx + CNT_W'(1);
                        end else if (w_wd_exp) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_wdog  <= '0;
                        end else begin
                            r_wdog <= r_wdog + WD_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_fcnt_frm_req    = (r_state == S_REQ);
    assign o_fcnt_frm_idx    = r_idx;
    assign o_fcnt_last_frame = (r_state == S_REQ) && w_last;
    assign o_fcnt_busy       = (r_state == S_REQ) || (r_state == S_DONE);
    assign o_fcnt_done       = (r_state == S_DONE);
    assign o_fcnt_err        = r_err;

endmodule
